// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: fetch vs LSU, LSU priority with a
// starvation limit and locked read->write pairs.
module mem_port_arbiter #(
  parameter int LSU_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] if_address,
  input  logic        if_read,
  output logic        if_done,
  input  logic [63:0] ls_address,
  input  logic [1:0]  ls_datasize,
  input  logic        ls_read,
  input  logic        ls_write,
  input  logic [63:0] ls_writedata,
  input  logic        ls_lock,
  output logic        ls_done,
  output logic [63:0] mem_address,
  output logic [1:0]  mem_datasize,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  input  logic        mem_done,
  input  logic [63:0] mem_readdata,
  output logic        proto_err
);

  localparam int CW = $clog2(LSU_BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LSU_BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF,
    S_LSU
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] burst_cnt, burst_nx;
  logic          ls_req;
  logic          at_max;
  logic          grant_ls;
  logic          grant_if;
  logic          rd_unused;

  assign ls_req    = ls_read | ls_write;
  assign at_max    = (burst_cnt == CNT_MAX);
  assign grant_ls  = ls_req & ~(if_read & at_max);
  assign grant_if  = if_read & ~grant_ls;
  assign rd_unused = ^mem_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
      if (state == S_LSU && ls_read && ls_write)
        proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx      = state;
    burst_nx      = burst_cnt;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_datasize  = '0;
    mem_writedata = '0;
    if_done       = 1'b0;
    ls_done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          grant_ls: state_nx = S_LSU;
          grant_if: state_nx = S_IF;
          default:  state_nx = S_IDLE;
        endcase
      end
      S_IF: begin
        mem_read     = 1'b1;
        mem_datasize = 2'b11;
        mem_address  = if_address;
        if (mem_done) begin
          if_done  = 1'b1;
          burst_nx = '0;
          state_nx = S_IDLE;
        end
      end
      S_LSU: begin
        // Read wins when both are raised; proto_err flags it.
        mem_read      = ls_read;
        mem_write     = ls_write & ~ls_read;
        mem_address   = ls_address;
        mem_datasize  = ls_datasize;
        mem_writedata = ls_writedata;
        if (mem_done) begin
          ls_done = 1'b1;
          if (!if_read)
            burst_nx = '0;
          else if (!at_max)
            burst_nx = burst_cnt + CW'(1);
          state_nx = ls_lock ? S_LSU : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level ownership model.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] if_address;
  logic        if_read;
  logic        if_done;
  logic [63:0] ls_address;
  logic [1:0]  ls_datasize;
  logic        ls_read;
  logic        ls_write;
  logic [63:0] ls_writedata;
  logic        ls_lock;
  logic        ls_done;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic        mem_done;
  logic [63:0] mem_readdata;
  logic        proto_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LSU_BURST_MAX(MAX)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .if_address(if_address),
    .if_read(if_read),
    .if_done(if_done),
    .ls_address(ls_address),
    .ls_datasize(ls_datasize),
    .ls_read(ls_read),
    .ls_write(ls_write),
    .ls_writedata(ls_writedata),
    .ls_lock(ls_lock),
    .ls_done(ls_done),
    .mem_address(mem_address),
    .mem_datasize(mem_datasize),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_done(mem_done),
    .mem_readdata(mem_readdata),
    .proto_err(proto_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_address   = '0;
    if_read      = 1'b0;
    ls_address   = '0;
    ls_datasize  = '0;
    ls_read      = 1'b0;
    ls_write     = 1'b0;
    ls_writedata = '0;
    ls_lock      = 1'b0;
    mem_done     = 1'b0;
    mem_readdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({mem_read, mem_write, if_done, ls_done, proto_err} !== 5'b0 ||
        mem_address !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ctl=%b addr=%h want 0",
        {mem_read, mem_write, if_done, ls_done, proto_err}, mem_address);
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    do_reset();
    tick();
    if_address = 64'h100;
    if_read = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_arb_latency: got mem_read=%b want 0", mem_read);
    end
    tick();
    #1;
    vectors++;
    if ({mem_read, mem_write, mem_datasize} !== 4'b1011 ||
        mem_address !== 64'h100) begin
      miscompares++;
      $display("FAIL fetch_grant: got rd=%b wr=%b sz=%0d addr=%h want 1 0 3 100",
        mem_read, mem_write, mem_datasize, mem_address);
    end
    tick();
    tick();
    #1;
    vectors++;
    if (if_done !== 1'b0 || mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_hold: got done=%b rd=%b want 0 1", if_done, mem_read);
    end
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (if_done !== 1'b1 || ls_done !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_done: got if_done=%b ls_done=%b want 1 0",
        if_done, ls_done);
    end
    tick();
    mem_done = 1'b0;
    if_read = 1'b0;
    #1;
    vectors++;
    if (if_done !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_release: got if_done=%b rd=%b want 0 0",
        if_done, mem_read);
    end
  endtask

  task automatic test_priority();
    do_reset();
    tick();
    if_read = 1'b1;
    if_address = 64'h100;
    ls_read = 1'b1;
    ls_address = 64'h2000;
    ls_datasize = 2'd1;
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 64'h2000 ||
        mem_datasize !== 2'd1 || ls_done !== 1'b1 || if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL lsu_first: got rd=%b addr=%h sz=%0d lsd=%b ifd=%b want 1 2000 1 1 0",
        mem_read, mem_address, mem_datasize, ls_done, if_done);
    end
    tick();
    mem_done = 1'b0;
    ls_read = 1'b0;
    #1;
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_bubble: got mem_read=%b want 0", mem_read);
    end
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 64'h100 ||
        mem_datasize !== 2'd3 || if_done !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_second: got rd=%b addr=%h sz=%0d ifd=%b want 1 100 3 1",
        mem_read, mem_address, mem_datasize, if_done);
    end
    tick();
    mem_done = 1'b0;
    if_read = 1'b0;
  endtask

  task automatic test_burst();
    logic [63:0] a;
    do_reset();
    tick();
    if_read = 1'b1;
    if_address = 64'h300;
    ls_read = 1'b1;
    ls_address = 64'h4000;
    for (int i = 0; i < MAX; i++) begin
      tick();
      mem_done = 1'b1;
      #1;
      a = 64'h4000 + 64'(i * 8);
      vectors++;
      if (mem_address !== a || ls_done !== 1'b1 || if_done !== 1'b0) begin
        miscompares++;
        $display("FAIL burst_lsu%0d: got addr=%h lsd=%b ifd=%b want %h 1 0",
          i, mem_address, ls_done, if_done, a);
      end
      tick();
      mem_done = 1'b0;
      ls_address = a + 64'h8;
    end
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (mem_address !== 64'h300 || if_done !== 1'b1 || ls_done !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_forced: got addr=%h ifd=%b lsd=%b want 300 1 0",
        mem_address, if_done, ls_done);
    end
    tick();
    mem_done = 1'b0;
    ls_address = 64'h5000;
    tick();
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 64'h5000) begin
      miscompares++;
      $display("FAIL burst_cnt_cleared: got rd=%b addr=%h want 1 5000",
        mem_read, mem_address);
    end
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    if_read = 1'b0;
    ls_read = 1'b0;
  endtask

  task automatic test_cswap();
    do_reset();
    tick();
    if_read = 1'b1;
    if_address = 64'h500;
    ls_read = 1'b1;
    ls_lock = 1'b1;
    ls_address = 64'h6000;
    ls_datasize = 2'd3;
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || ls_done !== 1'b1) begin
      miscompares++;
      $display("FAIL cswap_read: got rd=%b wr=%b lsd=%b want 1 0 1",
        mem_read, mem_write, ls_done);
    end
    tick();
    mem_done = 1'b0;
    ls_read = 1'b0;
    ls_lock = 1'b0;
    #1;
    vectors++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL cswap_hold: got rd=%b wr=%b want 0 0", mem_read, mem_write);
    end
    tick();
    ls_write = 1'b1;
    ls_writedata = 64'hCAFE_F00D_1234_5678;
    #1;
    vectors++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_address !== 64'h6000 || mem_writedata !== 64'hCAFE_F00D_1234_5678) begin
      miscompares++;
      $display("FAIL cswap_write: got rd=%b wr=%b addr=%h wd=%h want 0 1 6000 cafef00d12345678",
        mem_read, mem_write, mem_address, mem_writedata);
    end
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (ls_done !== 1'b1 || if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL cswap_wdone: got lsd=%b ifd=%b want 1 0", ls_done, if_done);
    end
    tick();
    mem_done = 1'b0;
    ls_write = 1'b0;
    tick();
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_address !== 64'h500) begin
      miscompares++;
      $display("FAIL cswap_fetch_after: got rd=%b addr=%h want 1 500",
        mem_read, mem_address);
    end
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    if_read = 1'b0;
  endtask

  task automatic test_proto();
    do_reset();
    tick();
    ls_read = 1'b1;
    ls_write = 1'b1;
    ls_address = 64'h7000;
    #1;
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL proto_initial: got %b want 0", proto_err);
    end
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || ls_done !== 1'b1) begin
      miscompares++;
      $display("FAIL proto_read_wins: got rd=%b wr=%b lsd=%b want 1 0 1",
        mem_read, mem_write, ls_done);
    end
    tick();
    mem_done = 1'b0;
    ls_read = 1'b0;
    ls_write = 1'b0;
    #1;
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL proto_set: got %b want 1", proto_err);
    end
    tick();
    ls_write = 1'b1;
    ls_writedata = 64'h55;
    tick();
    mem_done = 1'b1;
    #1;
    vectors++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL proto_sticky: got wr=%b rd=%b perr=%b want 1 0 1",
        mem_write, mem_read, proto_err);
    end
    tick();
    mem_done = 1'b0;
    ls_write = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    #1;
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL proto_cleared: got %b want 0", proto_err);
    end
    tick();
    ls_write = 1'b1;
    ls_address = 64'h8000;
    tick();
    #1;
    vectors++;
    if (mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_granted: got wr=%b want 1", mem_write);
    end
    #1;
    reset_n = 1'b0;
    ls_write = 1'b0;
    #1;
    vectors++;
    if ({mem_read, mem_write, if_done, ls_done} !== 4'b0 ||
        mem_address !== 64'h0) begin
      miscompares++;
      $display("FAIL rmid_async: got ctl=%b addr=%h want 0",
        {mem_read, mem_write, if_done, ls_done}, mem_address);
    end
    tick();
    reset_n = 1'b1;
    mem_done = 1'b1;
    #1;
    vectors++;
    if (ls_done !== 1'b0 || if_done !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_no_done: got lsd=%b ifd=%b wr=%b want 0 0 0",
        ls_done, if_done, mem_write);
    end
    tick();
    mem_done = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_idle: got wr=%b rd=%b want 0 0", mem_write, mem_read);
    end
  endtask

  // Model: who owns the port, and how many LSU transfers fetch has
  // watched complete since it last got served.
  task automatic test_random();
    int          owner;
    int          streak;
    bit          if_drop;
    bit          ls_drop;
    bit          busy;
    int          lat;
    logic        e_rd;
    logic        e_wr;
    logic        e_ifd;
    logic        e_lsd;
    logic [1:0]  e_sz;
    logic [63:0] e_addr;
    logic [63:0] e_wd;
    owner = 0;
    streak = 0;
    if_drop = 1'b0;
    ls_drop = 1'b0;
    busy = 1'b0;
    lat = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      mem_done = busy && lat == 0;
      mem_readdata = {$urandom, $urandom};
      if (if_drop) begin
        if_read = 1'b0;
        if_drop = 1'b0;
      end else if (!if_read && $urandom_range(0, 1) == 1) begin
        if_read = 1'b1;
        if_address = {$urandom, $urandom};
      end
      if (ls_drop) begin
        ls_read = 1'b0;
        ls_write = 1'b0;
        ls_drop = 1'b0;
      end else if (!ls_read && !ls_write && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 1) ls_read = 1'b1;
        else ls_write = 1'b1;
        ls_address = {$urandom, $urandom};
        ls_datasize = 2'($urandom_range(0, 3));
        ls_writedata = {$urandom, $urandom};
      end
      #1;
      e_rd   = (owner == 1) || (owner == 2 && ls_read);
      e_wr   = (owner == 2) && ls_write;
      e_addr = owner == 1 ? if_address : owner == 2 ? ls_address : 64'h0;
      e_sz   = owner == 1 ? 2'd3 : owner == 2 ? ls_datasize : 2'd0;
      e_wd   = owner == 2 ? ls_writedata : 64'h0;
      e_ifd  = (owner == 1) && mem_done;
      e_lsd  = (owner == 2) && mem_done;
      vectors++;
      if ({mem_read, mem_write, if_done, ls_done, proto_err} !==
          {e_rd, e_wr, e_ifd, e_lsd, 1'b0} || mem_datasize !== e_sz ||
          mem_address !== e_addr || mem_writedata !== e_wd) begin
        miscompares++;
        $display("FAIL rand_cyc%0d: got ctl=%b sz=%0d addr=%h want ctl=%b sz=%0d addr=%h",
          c, {mem_read, mem_write, if_done, ls_done, proto_err}, mem_datasize,
          mem_address, {e_rd, e_wr, e_ifd, e_lsd, 1'b0}, e_sz, e_addr);
      end
      if (mem_done) busy = 1'b0;
      else if (e_rd || e_wr) begin
        if (!busy) begin
          busy = 1'b1;
          lat = $urandom_range(0, 3);
        end else if (lat > 0) lat--;
      end
      if (owner == 0) begin
        if ((ls_read || ls_write) && if_read) owner = (streak == MAX) ? 1 : 2;
        else if (ls_read || ls_write) owner = 2;
        else if (if_read) owner = 1;
      end else if (mem_done) begin
        if (owner == 1) begin
          streak = 0;
          if_drop = 1'b1;
        end else begin
          streak = if_read ? ((streak < MAX) ? streak + 1 : MAX) : 0;
          ls_drop = 1'b1;
        end
        owner = 0;
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_burst();
    test_cswap();
    test_proto();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
